// File: rtl/shift_reg_sequencer_pkg.sv
// Shared types and defaults for the two-requester shift-register sequencer.
package shift_reg_sequencer_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } seq_state_t;

endpackage

// File: rtl/shift_reg_en.sv
// Right-shifting register with enable: SID enters at the MSB, the LSB falls off.
module shift_reg_en
    import shift_reg_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             SID,
    input  logic             ShiftEn,
    output logic [WIDTH-1:0] Q
);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            Q <= '0;
        end else if (ShiftEn) begin
            Q <= {SID, Q[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/shift_reg_sequencer.sv
// Round-robin arbitration between two requesters; the granted word is
// serialised LSB first into shift_reg_en, followed by a one-cycle Done pulse.
module shift_reg_sequencer
    import shift_reg_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned CNT_W = 3
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Req0,
    input  logic [WIDTH-1:0] Data0,
    output logic             Gnt0,
    input  logic             Req1,
    input  logic [WIDTH-1:0] Data1,
    output logic             Gnt1,
    output logic             SID,
    output logic             ShiftEn,
    output logic [WIDTH-1:0] Q,
    output logic             Busy,
    output logic             Done,
    output logic             Owner
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    seq_state_t       state_q, state_d;
    logic [WIDTH-1:0] hold_q;
    logic [CNT_W-1:0] cnt_q;
    logic             owner_q;
    logic             prio_q;   // 1 = requester 1 wins a tie

    // Outputs are gated by Rst so nothing is granted or shifted in a reset cycle.
    always_comb begin
        state_d = state_q;
        Gnt0    = 1'b0;
        Gnt1    = 1'b0;
        ShiftEn = 1'b0;
        SID     = 1'b0;
        Done    = 1'b0;
        Busy    = 1'b0;
        if (!Rst) begin
            case (state_q)
                IDLE: begin
                    Gnt0 = Req0 && (!Req1 || !prio_q);
                    Gnt1 = Req1 && (!Req0 ||  prio_q);
                    if (Gnt0 || Gnt1) begin
                        state_d = SHIFT;
                    end
                end
                SHIFT: begin
                    Busy    = 1'b1;
                    ShiftEn = 1'b1;
                    SID     = hold_q[cnt_q];
                    if (cnt_q == LAST_CNT) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    Busy    = 1'b1;
                    Done    = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= IDLE;
            hold_q  <= '0;
            cnt_q   <= '0;
            owner_q <= 1'b0;
            prio_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (Gnt0 || Gnt1) begin
                hold_q  <= Gnt1 ? Data1 : Data0;
                owner_q <= Gnt1;
                prio_q  <= Gnt0;
                cnt_q   <= '0;
            end else if (ShiftEn) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign Owner = owner_q;

    shift_reg_en #(
        .WIDTH (WIDTH)
    ) u_shift_reg (
        .Clk     (Clk),
        .Rst     (Rst),
        .SID     (SID),
        .ShiftEn (ShiftEn),
        .Q       (Q)
    );

endmodule

// File: tb/tb_shift_reg_sequencer.sv
// Directed bench for shift_reg_sequencer: arbitration table plus hand-written
// transfer, back-to-back, busy-request, mid-transfer reset and hold sequences.
module tb_shift_reg_sequencer;

    localparam int unsigned W = 8;

    logic         Clk = 1'b0;
    logic         Rst, Req0, Req1, Gnt0, Gnt1, SID, ShiftEn, Busy, Done, Owner;
    logic [W-1:0] Data0, Data1, Q;

    int checks   = 0;
    int failures = 0;

    shift_reg_sequencer #(.WIDTH(W), .CNT_W(3)) dut (
        .Clk(Clk), .Rst(Rst),
        .Req0(Req0), .Data0(Data0), .Gnt0(Gnt0),
        .Req1(Req1), .Data1(Data1), .Gnt1(Gnt1),
        .SID(SID), .ShiftEn(ShiftEn), .Q(Q),
        .Busy(Busy), .Done(Done), .Owner(Owner)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        string name;
        logic  rst, r0, r1;
        logic  g0, g1;
    } arb_vec_t;

    arb_vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic do_reset();
        Rst  = 1'b1;
        Req0 = 1'b0;
        Req1 = 1'b0;
        tick();
        tick();
        Rst = 1'b0;
    endtask

    // Called at the negedge right after the grant edge; ends in the Done cycle.
    // raise1_at >= 0 raises Req1 (with data d1) during that shift cycle.
    task automatic expect_shift(input logic [W-1:0] d, input string tag,
                                input int raise1_at, input logic [W-1:0] d1);
        logic [W-1:0] dv;
        dv = d;
        for (int i = 0; i < int'(W); i++) begin
            check({tag, "_shift"}, 32'({Gnt0, Gnt1, ShiftEn, SID, Done}),
                  32'({1'b0, 1'b0, 1'b1, dv[i], 1'b0}));
            if (i == raise1_at) begin
                Req1  = 1'b1;
                Data1 = d1;
            end
            tick();
        end
        check({tag, "_done"},  32'({Done, ShiftEn, Busy, Gnt0, Gnt1}), 32'(5'b10100));
        check({tag, "_q"},     32'(Q), 32'(d));
    endtask

    initial begin
        int done_cycles[$];
        int cyc;

        Rst   = 1'b1;
        Req0  = 1'b0;
        Req1  = 1'b0;
        Data0 = '0;
        Data1 = '0;

        vecs[0] = '{"arb_none", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{"arb_r0",   1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{"arb_r1",   1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[3] = '{"arb_both", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{"arb_rst",  1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

        // Reset: outputs quiet while Rst is held and just after
        tick();
        check("rst_during", 32'({Gnt0, Gnt1, ShiftEn, SID, Done, Busy}), 32'(0));
        tick();
        Rst = 1'b0;
        #1;
        check("rst_after_ctl", 32'({Gnt0, Gnt1, ShiftEn, SID, Done, Busy, Owner}), 32'(0));
        check("rst_after_q", 32'(Q), 32'(0));

        // Combinational arbitration in IDLE, inputs removed before each edge
        foreach (vecs[k]) begin
            Rst  = vecs[k].rst;
            Req0 = vecs[k].r0;
            Req1 = vecs[k].r1;
            #1;
            check(vecs[k].name, 32'({Gnt0, Gnt1}), 32'({vecs[k].g0, vecs[k].g1}));
            Rst  = 1'b0;
            Req0 = 1'b0;
            Req1 = 1'b0;
            @(negedge Clk);
        end

        // Single transfer of A5 from requester 0
        do_reset();
        Req0  = 1'b1;
        Data0 = 8'hA5;
        #1;
        check("a5_gnt", 32'({Gnt0, Gnt1, Busy}), 32'(3'b100));
        tick();
        Req0 = 1'b0;
        expect_shift(8'hA5, "a5", -1, '0);
        check("a5_owner", 32'(Owner), 32'(0));
        tick();
        check("a5_idle", 32'({Busy, Done, ShiftEn}), 32'(0));
        check("a5_qhold", 32'(Q), 32'(8'hA5));
        // Requester 0 was served last, so a tie now goes to requester 1
        Req0 = 1'b1;
        Req1 = 1'b1;
        #1;
        check("rr_after0", 32'({Gnt0, Gnt1}), 32'(2'b01));
        Req0 = 1'b0;
        Req1 = 1'b0;

        // Simultaneous requests from reset: 0 first, then 1 right after Done
        do_reset();
        Req0  = 1'b1;
        Req1  = 1'b1;
        Data0 = 8'h0F;
        Data1 = 8'hF0;
        #1;
        check("both_gnt0", 32'({Gnt0, Gnt1}), 32'(2'b10));
        tick();
        Req0 = 1'b0;
        expect_shift(8'h0F, "both0", -1, 8'hF0);
        check("both0_owner", 32'(Owner), 32'(0));
        tick();
        check("both_gnt1", 32'({Gnt0, Gnt1}), 32'(2'b01));
        tick();
        Req1 = 1'b0;
        expect_shift(8'hF0, "both1", -1, '0);
        check("both1_owner", 32'(Owner), 32'(1));
        tick();
        Req0 = 1'b1;
        Req1 = 1'b1;
        #1;
        check("rr_after1", 32'({Gnt0, Gnt1}), 32'(2'b10));
        Req0 = 1'b0;
        Req1 = 1'b0;

        // Req1 raised during the third shift cycle waits for the IDLE cycle
        do_reset();
        Req0  = 1'b1;
        Data0 = 8'h5A;
        tick();
        Req0 = 1'b0;
        expect_shift(8'h5A, "busy0", 2, 8'hC3);
        check("busy_owner0", 32'(Owner), 32'(0));
        tick();
        check("busy_gnt1", 32'({Gnt0, Gnt1, Busy}), 32'(3'b010));
        check("busy_qkeep", 32'(Q), 32'(8'h5A));
        tick();
        Req1 = 1'b0;
        expect_shift(8'hC3, "busy1", -1, '0);
        check("busy_owner1", 32'(Owner), 32'(1));
        tick();

        // Reset after four shifts of FF
        do_reset();
        Req0  = 1'b1;
        Data0 = 8'hFF;
        tick();
        Req0 = 1'b0;
        repeat (4) tick();
        check("mid_q4", 32'({Q, Busy, ShiftEn}), 32'({8'hF0, 2'b11}));
        Rst = 1'b1;
        #1;
        check("mid_rst_out", 32'({Busy, ShiftEn, SID, Done, Gnt0, Gnt1}), 32'(0));
        tick();
        Rst = 1'b0;
        #1;
        check("mid_after", 32'({Q, Busy, Done, Owner, ShiftEn}), 32'(0));
        cyc = 0;
        for (int i = 0; i < 12; i++) begin
            if (Done) cyc++;
            tick();
        end
        check("mid_no_done", 32'(cyc), 32'(0));

        // Three back-to-back transfers with Req0 held
        do_reset();
        Req0  = 1'b1;
        Data0 = 8'h3C;
        cyc   = 0;
        while (done_cycles.size() < 3 && cyc < 60) begin
            if (Done) begin
                done_cycles.push_back(cyc);
                check("b2b_q", 32'(Q), 32'(8'h3C));
                if (done_cycles.size() == 3) Req0 = 1'b0;
            end
            if (done_cycles.size() < 3) begin
                tick();
                cyc++;
            end
        end
        check("b2b_count", 32'(done_cycles.size()), 32'(3));
        if (done_cycles.size() == 3) begin
            check("b2b_gap1", 32'(done_cycles[1] - done_cycles[0]), 32'(W + 2));
            check("b2b_gap2", 32'(done_cycles[2] - done_cycles[1]), 32'(W + 2));
        end

        // Idle with no requests: Q holds, nothing granted or shifted
        tick();
        for (int i = 0; i < 20; i++) begin
            check("hold", 32'({Q, ShiftEn, Gnt0, Gnt1, Busy}), 32'({8'h3C, 4'b0000}));
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/shift_reg_sequencer.md
SHIFT_REG_SEQUENCER -- requirements
Module: shift_reg_sequencer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, the shift-register length and data width in bits.
REQ-002 The block SHALL have parameter CNT_W, default 3, the shift-counter width, equal to clog2(WIDTH).
REQ-003 The block SHALL have port Clk, input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port Rst, input, 1 bit, the reset, which SHALL be synchronous and active-high.
REQ-005 The block SHALL have port Req0, input, 1 bit, the load request from requester 0.
REQ-006 The block SHALL have port Data0, input, WIDTH bits, the byte offered by requester 0.
REQ-007 The block SHALL have port Gnt0, output, 1 bit, the grant to requester 0.
REQ-008 The block SHALL have ports Req1, Data1 and Gnt1, identical to Req0, Data0 and Gnt0, for requester 1.
REQ-009 The block SHALL have port SID, output, 1 bit, the serial input driven into the shift register.
REQ-010 The block SHALL have port ShiftEn, output, 1 bit, the shift enable driven to the shift register.
REQ-011 The block SHALL have port Q, output, WIDTH bits, the shift-register contents.
REQ-012 The block SHALL have port Busy, output, 1 bit, high in every state other than IDLE.
REQ-013 The block SHALL have port Done, output, 1 bit, a one-cycle completion pulse.
REQ-014 The block SHALL have port Owner, output, 1 bit, the index of the requester most recently granted.

Function
REQ-015 The block SHALL implement three states: IDLE, SHIFT and DONE.
REQ-016 In IDLE, Gnt0 and Gnt1 SHALL be a combinational function of Req0, Req1 and the round-robin pointer; at most one grant SHALL be high, and never both.
REQ-017 Arbitration SHALL work as follows: one request wins outright; with both requests high, the requester other than the last one served SHALL win; after reset, requester 0 SHALL be favoured.
REQ-018 On an edge in IDLE with a grant high:
- the granted Data SHALL be latched into the hold register;
- Owner SHALL be updated to the granted index;
- the pointer SHALL be updated;
- the counter SHALL be cleared to 0;
- the state SHALL move to SHIFT.
REQ-019 Gnt0 and Gnt1 SHALL be low in SHIFT and DONE; requests arriving then SHALL be ignored, and a requester SHALL hold Req high until its grant is seen.
REQ-020 In SHIFT, ShiftEn SHALL be 1 and SID SHALL equal hold[cnt]; the counter SHALL increment on each edge, so the byte is sent LSB first.
REQ-021 On each edge with ShiftEn high, Q SHALL shift right: Q[WIDTH-1] takes SID, Q[i-1] takes Q[i], and the old Q[0] is discarded.
REQ-022 After WIDTH shift cycles, with cnt at WIDTH-1, the state SHALL move to DONE; Q SHALL then equal the latched data exactly.
REQ-023 In DONE, Done SHALL be 1 and ShiftEn SHALL be 0 for exactly one cycle, after which the state SHALL return to IDLE.
REQ-024 Latency SHALL be fixed: with the grant edge at T, the shifts occur on edges T+1 through T+WIDTH and Done is high during the cycle after edge T+WIDTH.
REQ-025 Back-to-back transfers SHALL be allowed: a request held high is granted in the IDLE cycle that immediately follows DONE.
REQ-026 Q SHALL hold its value whenever ShiftEn is 0.

Reset
REQ-027 When Rst is high at an edge, the following SHALL be applied, including mid-SHIFT or in DONE:
- state SHALL go to IDLE;
- Q, the hold register and the counter SHALL go to 0;
- Owner SHALL go to 0;
- the pointer SHALL favour requester 0.
REQ-028 During and immediately after reset, Gnt0, Gnt1, ShiftEn, SID, Done and Busy SHALL all be 0.
REQ-029 Rst SHALL take priority over every other input in the same cycle.

Structure
REQ-030 A shared package SHALL hold the state enum type (IDLE, SHIFT, DONE) and the default constant WIDTH = 8.
REQ-031 The register SHALL be a single sub-module, shift_reg_en, with ports SID, ShiftEn, Clk, Rst and Q; it SHALL be edge-triggered with a synchronous clear.
REQ-032 The arbiter, FSM, counter and hold register SHALL reside in shift_reg_sequencer itself.

Verification
REQ-033 The bench SHALL drive Rst for 2 cycles, then a single request: Req0 = 1 with Data0 = 8'hA5 -> Gnt0 high for 1 cycle, then 8 cycles of ShiftEn with SID sequence 1,0,1,0,0,1,0,1, then Done = 1, Q = 8'hA5, Owner = 0.
REQ-034 The bench SHALL drive simultaneous requests: Req0 = Req1 = 1 from reset, with Data0 = 8'h0F and Data1 = 8'hF0 -> requester 0 is served first with Q = 8'h0F; requester 1 is served next with Gnt1 in the cycle after Done and Q = 8'hF0; Owner goes 0 then 1.
REQ-035 The bench SHALL drive a request during Busy: Req1 raised at cycle 3 of SHIFT -> Gnt1 stays 0 until the IDLE cycle after Done; the first transfer's Q is unaffected.
REQ-036 The bench SHALL assert reset mid-operation: Rst = 1 after 4 shifts of 8'hFF -> next cycle state is IDLE, Q = 8'h00, Busy = 0, Done never pulses.
REQ-037 The bench SHALL run repeated back-to-back transfers: Req0 held high with Data0 = 8'h3C for 3 transfers -> Done pulses spaced exactly WIDTH+2 = 10 cycles apart; Q = 8'h3C after each.
REQ-038 The bench SHALL check Q holding: with no requests for 20 cycles after a transfer -> Q is stable and ShiftEn, Gnt0 and Gnt1 stay at 0.
